gl_triangle_feeder: RTL and testbench
=====================================

Name: gl_triangle_feeder

Overview:
Producer end of the rasterizer's triangle input interface (fifo_in1/2/3, fifo_ready, raster_ready).
- Accepts single vertices (x, y, z as IEEE-754 single, packed {x,y,z} into 96 bits) from the upstream vertex path.
- Assembles every three consecutive vertices into one triangle.
- Buffers up to DEPTH triangles in a FIFO.
- Presents the head triangle to gl_rasterizer, popping it when the rasterizer signals it has taken it.

Parameters:
DEPTH, 4, triangle FIFO depth; power of two, >= 2
VW, 96, vertex width in bits ({x[95:64], y[63:32], z[31:0]})

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
vtx_valid  input  1  upstream vertex present on vtx_data
vtx_data  input  VW  vertex {x,y,z}
vtx_ready  output  1  feeder accepts vtx_data this cycle
tri_flush  input  1  discard partially assembled triangle
fifo_in1  output  VW  head triangle vertex 0
fifo_in2  output  VW  head triangle vertex 1
fifo_in3  output  VW  head triangle vertex 2
fifo_ready  output  1  head triangle valid (FIFO not empty)
raster_ready  input  1  one-cycle pulse: rasterizer latched head triangle, pop it
tri_count  output  $clog2(DEPTH)+1  triangles currently stored

Behaviour:
- Clock and reset are fixed:
  - One clock, clk.
  - Reset is asynchronous and active-low, rst_n.
- Reset values:
  - vtx_ready=1, fifo_ready=0, tri_count=0.
  - fifo_in1..3 = 0.
  - Assembly index = 0; read and write pointers = 0.
- Vertex accept:
  - A vertex is taken when vtx_valid && vtx_ready.
  - Assembly index advances 0->1->2->0.
  - Index 0 stores slot A; index 1 stores slot B.
  - Index 2 writes {A, B, vtx_data} as one FIFO entry on the same edge and returns the index to 0.
- Back-pressure:
  - vtx_ready = !(index==2 && tri_count==DEPTH).
  - Vertices 0 and 1 are always accepted.
  - vtx_ready is a function of registered state only; there is no combinational path from raster_ready.
  - A pop in cycle N raises vtx_ready in cycle N+1.
- Output:
  - fifo_ready = (tri_count != 0).
  - fifo_in1..3 are driven from the head entry, registered or RAM-read with zero added latency.
  - A write into an empty FIFO shows fifo_ready=1 in the cycle after the write edge.
- Pop:
  - raster_ready && fifo_ready advances the read pointer and decrements tri_count.
  - raster_ready while empty is ignored; no state change.
- Simultaneous push and pop:
  - tri_count is unchanged.
  - Both pointers advance.
  - When the FIFO is full this cannot happen, because the push is blocked.
- Pointer wrap:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Full/empty are derived from tri_count, not from pointer compare.
- tri_flush:
  - Forces the assembly index to 0 on the next edge. Stored triangles are unaffected.
  - If asserted together with an accepted vertex, flush wins and the vertex is dropped, including a third vertex, which is not written.
- Reset mid-operation: all stored triangles and any partial assembly are discarded immediately (asynchronous).
- No arithmetic is performed on the float fields; they pass through bit-exact.

Decomposition:
- Shared package gl_pkg holds:
  - VW = 96.
  - Field slice constants X_MSB/X_LSB, Y_MSB/Y_LSB, Z_MSB/Z_LSB.
  - Float constants FP_ONE=32'h3F800000, FP_TWO=32'h40000000, FP_TEN=32'h41200000, used by the rasterizer benches as well.
- One natural sub-module, gl_tri_fifo:
  - Generic 3*VW-wide, DEPTH-deep synchronous FIFO with push, pop, full, empty and count.
  - It is instantiated by gl_triangle_feeder, which keeps the assembly index, slots A/B, flush and back-pressure logic.

Test Plan:
1. Single triangle:
   - Stimulus: after reset, send (1,10,0), (1,1,0), (10,1,0), i.e. 3F800000_41200000_00000000, 3F800000_3F800000_00000000, 41200000_3F800000_00000000, with raster_ready=0.
   - Required: fifo_ready=1 one cycle after the third accept, fifo_in1..3 equal those words in order, tri_count=1.
   - Then: pulse raster_ready. Required: fifo_ready=0 and tri_count=0 next cycle.
2. Fill and back-pressure:
   - Stimulus: push 4 triangles with vertex x = FP_ONE..distinct values, then 2 more vertices.
   - Required: both extra vertices accepted, vtx_ready=0 on the 3rd, tri_count=4.
   - Then: one pop. Required: vtx_ready=1 the following cycle, the pending vertex is accepted, tri_count returns to 4, and order is preserved.
3. Simultaneous push/pop:
   - Stimulus: with tri_count=2, the third-vertex accept and raster_ready occur in the same cycle.
   - Required: tri_count stays 2 and the head advances to triangle 2.
4. Pop while empty:
   - Stimulus: raster_ready pulses with tri_count=0.
   - Required: no pointer change; the next pushed triangle appears correctly at the head.
5. Flush:
   - Stimulus: two vertices accepted, then tri_flush, then three new vertices.
   - Required: exactly one triangle stored, containing only the three new vertices. Flush coincident with a third vertex stores nothing.
6. Async reset mid-stream:
   - Stimulus: rst_n low for 3 ns between edges with tri_count=3 and index=1.
   - Required: fifo_ready=0, tri_count=0 and vtx_ready=1 immediately; the next three vertices form triangle 0.

Source files
------------

// File: rtl/gl_pkg.sv
// Shared vertex layout and float constants for the triangle feeder and rasterizer benches.
// Pure declarations; no logic, no latency.
// Vertices are {x, y, z} IEEE-754 singles and pass through every block bit-exact.
package gl_pkg;

    localparam int VW = 96;

    localparam int X_MSB = 95;
    localparam int X_LSB = 64;
    localparam int Y_MSB = 63;
    localparam int Y_LSB = 32;
    localparam int Z_MSB = 31;
    localparam int Z_LSB = 0;

    localparam logic [31:0] FP_ONE = 32'h3F80_0000;
    localparam logic [31:0] FP_TWO = 32'h4000_0000;
    localparam logic [31:0] FP_TEN = 32'h4120_0000;

    typedef logic [VW-1:0] vtx_t;

    function automatic vtx_t mk_vtx(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        vtx_t v;
        v[X_MSB:X_LSB] = x;
        v[Y_MSB:Y_LSB] = y;
        v[Z_MSB:Z_LSB] = z;
        return v;
    endfunction

endpackage

// File: rtl/gl_tri_fifo.sv
// Generic W-wide, DEPTH-deep synchronous FIFO with occupancy count.
// Latency: a push is visible at the head one edge later; head data is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; callers gate on full/empty.
module gl_tri_fifo #(
    parameter  int W     = 288,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Occupancy comes from the counter; pointers alone cannot tell full from empty.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gl_triangle_feeder.sv
// Assembles vertex triples into triangles and queues them for gl_rasterizer.
// Latency: triangle visible at fifo_in1..3 one cycle after its third vertex is accepted.
// Backpressure: vtx_ready drops only on a third vertex while the queue is full (registered state only).
module gl_triangle_feeder #(
    parameter int DEPTH = 4,
    parameter int VW    = 96
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vtx_valid,
    input  logic [VW-1:0]            vtx_data,
    output logic                     vtx_ready,
    input  logic                     tri_flush,
    output logic [VW-1:0]            fifo_in1,
    output logic [VW-1:0]            fifo_in2,
    output logic [VW-1:0]            fifo_in3,
    output logic                     fifo_ready,
    input  logic                     raster_ready,
    output logic [$clog2(DEPTH):0]   tri_count
);

    import gl_pkg::*;

    typedef struct packed {
        logic [VW-1:0] v0;
        logic [VW-1:0] v1;
        logic [VW-1:0] v2;
    } tri_t;

    localparam logic [1:0] IDX_A = 2'd0;
    localparam logic [1:0] IDX_B = 2'd1;
    localparam logic [1:0] IDX_C = 2'd2;

    logic [1:0]    idx;
    logic [VW-1:0] slot_a;
    logic [VW-1:0] slot_b;
    logic          vtx_acc;
    logic          tri_push_vld;
    tri_t          tri_push_dat;
    tri_t          tri_head_dat;
    logic          fifo_full;
    logic          fifo_empty;

    assign vtx_ready    = !((idx == IDX_C) && fifo_full);
    assign vtx_acc      = vtx_valid && vtx_ready;
    // A flush coincident with the closing vertex drops the whole triangle.
    assign tri_push_vld = vtx_acc && (idx == IDX_C) && !tri_flush;
    assign tri_push_dat = '{v0: slot_a, v1: slot_b, v2: vtx_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= IDX_A;
            slot_a <= '0;
            slot_b <= '0;
        end else if (tri_flush) begin
            idx <= IDX_A;
        end else if (vtx_acc) begin
            case (idx)
                IDX_A: begin
                    slot_a <= vtx_data;
                    idx    <= IDX_B;
                end
                IDX_B: begin
                    slot_b <= vtx_data;
                    idx    <= IDX_C;
                end
                default: idx <= IDX_A;
            endcase
        end
    end

    gl_tri_fifo #(
        .W     ($bits(tri_t)),
        .DEPTH (DEPTH)
    ) u_tri_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tri_push_vld),
        .push_dat (tri_push_dat),
        .pop      (raster_ready),
        .pop_dat  (tri_head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (tri_count)
    );

    assign fifo_ready = !fifo_empty;
    assign fifo_in1   = tri_head_dat.v0;
    assign fifo_in2   = tri_head_dat.v1;
    assign fifo_in3   = tri_head_dat.v2;

endmodule

// File: tb/tb_gl_triangle_feeder.sv
// Directed bench for gl_triangle_feeder: inputs driven and outputs sampled on the falling edge.
module tb_gl_triangle_feeder;

    import gl_pkg::*;

    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vtx_valid;
    logic [95:0]   vtx_data;
    logic          vtx_ready;
    logic          tri_flush;
    logic [95:0]   fifo_in1;
    logic [95:0]   fifo_in2;
    logic [95:0]   fifo_in3;
    logic          fifo_ready;
    logic          raster_ready;
    logic [2:0]    tri_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gl_triangle_feeder #(.DEPTH(DEPTH), .VW(96)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vtx_valid    (vtx_valid),
        .vtx_data     (vtx_data),
        .vtx_ready    (vtx_ready),
        .tri_flush    (tri_flush),
        .fifo_in1     (fifo_in1),
        .fifo_in2     (fifo_in2),
        .fifo_in3     (fifo_in3),
        .fifo_ready   (fifo_ready),
        .raster_ready (raster_ready),
        .tri_count    (tri_count)
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Vertex k.j: x tags the triangle, y tags the position, z is a constant.
    function automatic logic [95:0] tv(input int k, input int j);
        return mk_vtx(FP_ONE + 32'(k), FP_TWO + 32'(j), FP_TEN);
    endfunction

    // Called at a falling edge; returns at a falling edge after the vertex is taken.
    task automatic send(input logic [95:0] v);
        int n = 0;
        vtx_valid = 1'b1;
        vtx_data  = v;
        while (!vtx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!vtx_ready) chk("send_timeout", {95'd0, vtx_ready}, 96'd1);
        @(posedge clk);
        @(negedge clk);
        vtx_valid = 1'b0;
    endtask

    task automatic send_tri(input int k);
        for (int j = 0; j < 3; j++) send(tv(k, j));
    endtask

    task automatic pop();
        raster_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        raster_ready = 1'b0;
    endtask

    task automatic chk_head(input string tag, input int k);
        chk({tag, "_in1"}, fifo_in1, tv(k, 0));
        chk({tag, "_in2"}, fifo_in2, tv(k, 1));
        chk({tag, "_in3"}, fifo_in3, tv(k, 2));
    endtask

    initial begin
        rst_n        = 1'b0;
        vtx_valid    = 1'b0;
        vtx_data     = '0;
        tri_flush    = 1'b0;
        raster_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_vtx_ready", {95'd0, vtx_ready}, 96'd1);
        chk("rst_fifo_ready", {95'd0, fifo_ready}, 96'd0);
        chk("rst_count", {93'd0, tri_count}, 96'd0);
        chk("rst_in1", fifo_in1, 96'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Single triangle (1,10,0) (1,1,0) (10,1,0)
        send(96'h3F800000_41200000_00000000);
        send(96'h3F800000_3F800000_00000000);
        send(96'h41200000_3F800000_00000000);
        chk("t1_fifo_ready", {95'd0, fifo_ready}, 96'd1);
        chk("t1_in1", fifo_in1, 96'h3F800000_41200000_00000000);
        chk("t1_in2", fifo_in2, 96'h3F800000_3F800000_00000000);
        chk("t1_in3", fifo_in3, 96'h41200000_3F800000_00000000);
        chk("t1_count", {93'd0, tri_count}, 96'd1);
        pop();
        chk("t1_pop_ready", {95'd0, fifo_ready}, 96'd0);
        chk("t1_pop_count", {93'd0, tri_count}, 96'd0);

        // 2. Fill, back-pressure on the closing vertex, release by one pop
        for (int k = 1; k <= 4; k++) send_tri(k);
        chk("t2_full_count", {93'd0, tri_count}, 96'd4);
        chk("t2_v0_ready", {95'd0, vtx_ready}, 96'd1);
        send(tv(5, 0));
        chk("t2_v1_ready", {95'd0, vtx_ready}, 96'd1);
        send(tv(5, 1));
        vtx_valid = 1'b1;
        vtx_data  = tv(5, 2);
        chk("t2_v2_blocked", {95'd0, vtx_ready}, 96'd0);
        @(negedge clk);
        chk("t2_v2_still_blocked", {95'd0, vtx_ready}, 96'd0);
        raster_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        raster_ready = 1'b0;
        chk("t2_release_ready", {95'd0, vtx_ready}, 96'd1);
        chk("t2_release_count", {93'd0, tri_count}, 96'd3);
        @(posedge clk);
        @(negedge clk);
        vtx_valid = 1'b0;
        chk("t2_refill_count", {93'd0, tri_count}, 96'd4);
        for (int k = 2; k <= 5; k++) begin
            chk_head($sformatf("t2_order%0d", k), k);
            pop();
        end
        chk("t2_drained", {93'd0, tri_count}, 96'd0);

        // 3. Closing vertex and pop in the same cycle with two stored
        send_tri(6);
        send_tri(7);
        send(tv(8, 0));
        send(tv(8, 1));
        vtx_valid    = 1'b1;
        vtx_data     = tv(8, 2);
        raster_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vtx_valid    = 1'b0;
        raster_ready = 1'b0;
        chk("t3_count", {93'd0, tri_count}, 96'd2);
        chk_head("t3_head7", 7);
        pop();
        chk_head("t3_head8", 8);
        pop();

        // 4. Pop while empty is ignored
        pop();
        chk("t4_count", {93'd0, tri_count}, 96'd0);
        chk("t4_fifo_ready", {95'd0, fifo_ready}, 96'd0);
        send_tri(9);
        chk("t4_push_count", {93'd0, tri_count}, 96'd1);
        chk_head("t4_head9", 9);
        pop();

        // 5. Flush between vertices, then flush on a closing vertex
        send(tv(10, 0));
        send(tv(10, 1));
        tri_flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tri_flush = 1'b0;
        send_tri(11);
        chk("t5_count", {93'd0, tri_count}, 96'd1);
        chk_head("t5_head11", 11);
        send(tv(12, 0));
        send(tv(12, 1));
        vtx_valid = 1'b1;
        vtx_data  = tv(12, 2);
        tri_flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vtx_valid = 1'b0;
        tri_flush = 1'b0;
        chk("t5_flush_c_count", {93'd0, tri_count}, 96'd1);
        send_tri(13);
        chk("t5_after_count", {93'd0, tri_count}, 96'd2);
        pop();
        chk_head("t5_head13", 13);
        pop();

        // 6. Asynchronous reset between edges with three stored and one partial vertex
        send_tri(14);
        send_tri(15);
        send_tri(16);
        send(tv(17, 0));
        chk("t6_pre_count", {93'd0, tri_count}, 96'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_fifo_ready", {95'd0, fifo_ready}, 96'd0);
        chk("t6_rst_count", {93'd0, tri_count}, 96'd0);
        chk("t6_rst_vtx_ready", {95'd0, vtx_ready}, 96'd1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send_tri(18);
        chk("t6_post_count", {93'd0, tri_count}, 96'd1);
        chk_head("t6_head18", 18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
